// File: rtl/bcd_countdown_timer.sv
`default_nettype none
// ============================================================================
// Module   : bcd_countdown_timer
// Brief    : BCD MM..M:SS game timer, up/down, with start/pause/clear/load.
// Revision : 1.0 - initial release
// ============================================================================
module bcd_countdown_timer #(
    parameter int CLK_HZ     = 100_000_000,
    parameter int TICK_HZ    = 1,
    parameter int MIN_DIGITS = 2
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start,
    input  logic                          pause,
    input  logic                          clear,
    input  logic                          dir,
    input  logic                          load_en,
    input  logic [4*(MIN_DIGITS+2)-1:0]   load_value,
    output logic [4*(MIN_DIGITS+2)-1:0]   time_out,
    output logic [1:0]                    state_out,
    output logic                          tick,
    output logic                          expired,
    output logic                          load_err
);

    localparam int W    = 4 * (MIN_DIGITS + 2);
    localparam int NDIG = MIN_DIGITS + 2;
    localparam int DIV  = CLK_HZ / TICK_HZ;
    localparam int PW   = $clog2(DIV);
    localparam logic [PW-1:0] PRESC_LAST = PW'(DIV - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // Digit 1 is seconds tens (0..5); every other digit is a full decade.
    function automatic logic [3:0] digit_max(input int i);
        return (i == 1) ? 4'd5 : 4'd9;
    endfunction

    function automatic logic [W-1:0] full_scale();
        logic [W-1:0] r;
        r = '0;
        for (int i = 0; i < NDIG; i++) begin
            r[4*i +: 4] = digit_max(i);
        end
        return r;
    endfunction

    function automatic logic valid_bcd(input logic [W-1:0] v);
        logic ok;
        ok = 1'b1;
        for (int i = 0; i < NDIG; i++) begin
            if (v[4*i +: 4] > digit_max(i)) begin
                ok = 1'b0;
            end
        end
        return ok;
    endfunction

    function automatic logic [W-1:0] bcd_step(input logic [W-1:0] t, input logic down);
        logic [W-1:0] r;
        logic         carry;
        logic [3:0]   d;
        r     = t;
        carry = 1'b1;
        for (int i = 0; i < NDIG; i++) begin
            d = t[4*i +: 4];
            if (carry) begin
                if (down) begin
                    if (d == 4'd0) begin
                        r[4*i +: 4] = digit_max(i);
                    end else begin
                        r[4*i +: 4] = d - 4'd1;
                        carry       = 1'b0;
                    end
                end else begin
                    if (d == digit_max(i)) begin
                        r[4*i +: 4] = 4'd0;
                    end else begin
                        r[4*i +: 4] = d + 4'd1;
                        carry       = 1'b0;
                    end
                end
            end
        end
        return r;
    endfunction

    localparam logic [W-1:0] TIME_FULL = full_scale();

    state_t          state_q, state_d;
    logic [W-1:0]    time_q, time_d;
    logic [PW-1:0]   presc_q, presc_d;
    logic            dir_q, dir_d;
    logic            tick_q, tick_d;
    logic            expired_q, expired_d;
    logic            load_err_q, load_err_d;

    logic [W-1:0]    step_time;
    logic [W-1:0]    run_term;
    logic            start_at_term;

    always_comb begin
        state_d       = state_q;
        time_d        = time_q;
        presc_d       = presc_q;
        dir_d         = dir_q;
        tick_d        = 1'b0;
        expired_d     = 1'b0;
        load_err_d    = 1'b0;
        step_time     = bcd_step(time_q, dir_q);
        run_term      = dir_q ? '0 : TIME_FULL;
        // Starting already at the terminal value in the chosen direction ends at once.
        start_at_term = dir ? (time_q == '0) : (time_q == TIME_FULL);

        if (clear) begin
            state_d = ST_IDLE;
            time_d  = '0;
            presc_d = '0;
        end else if (load_en && (state_q != ST_RUN)) begin
            if (valid_bcd(load_value)) begin
                time_d  = load_value;
                presc_d = '0;
                if (state_q == ST_DONE) begin
                    state_d = ST_IDLE;
                end
            end else begin
                load_err_d = 1'b1;
            end
        end else if (pause && (state_q == ST_RUN)) begin
            state_d = ST_PAUSE;
        end else if (start && ((state_q == ST_IDLE) || (state_q == ST_PAUSE))) begin
            dir_d = dir;
            if (state_q == ST_IDLE) begin
                presc_d = '0;
            end
            if (start_at_term) begin
                state_d   = ST_DONE;
                expired_d = 1'b1;
            end else begin
                state_d = ST_RUN;
            end
        end else if (state_q == ST_RUN) begin
            if (presc_q == PRESC_LAST) begin
                presc_d = '0;
                time_d  = step_time;
                tick_d  = 1'b1;
                if (step_time == run_term) begin
                    state_d   = ST_DONE;
                    expired_d = 1'b1;
                end
            end else begin
                presc_d = presc_q + PW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            time_q     <= '0;
            presc_q    <= '0;
            dir_q      <= 1'b0;
            tick_q     <= 1'b0;
            expired_q  <= 1'b0;
            load_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            time_q     <= time_d;
            presc_q    <= presc_d;
            dir_q      <= dir_d;
            tick_q     <= tick_d;
            expired_q  <= expired_d;
            load_err_q <= load_err_d;
        end
    end

    assign time_out  = time_q;
    assign state_out = state_q;
    assign tick      = tick_q;
    assign expired   = expired_q;
    assign load_err  = load_err_q;

endmodule
`default_nettype wire

// File: tb/tb_bcd_countdown_timer.sv
`default_nettype none
// ============================================================================
// Module   : tb_bcd_countdown_timer
// Brief    : Directed + random bench for bcd_countdown_timer, seconds-based model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bcd_countdown_timer;

    localparam int CLK_HZ  = 10;
    localparam int TICK_HZ = 1;
    localparam int MD      = 2;
    localparam int W       = 4 * (MD + 2);
    localparam int DIV     = CLK_HZ / TICK_HZ;
    localparam int MAXS    = (10**MD - 1) * 60 + 59;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0, pause = 1'b0, clear = 1'b0, dir = 1'b0, load_en = 1'b0;
    logic [W-1:0] load_value = '0;
    logic [W-1:0] time_out;
    logic [1:0]   state_out;
    logic         tick, expired, load_err;

    int total = 0;
    int bad   = 0;
    int n_tick, n_exp;

    // Model: time kept as whole seconds, state as 0 IDLE / 1 RUN / 2 PAUSE / 3 DONE.
    int m_secs, m_state, m_presc;
    bit m_dir, m_tick, m_exp, m_lerr;

    bcd_countdown_timer #(.CLK_HZ(CLK_HZ), .TICK_HZ(TICK_HZ), .MIN_DIGITS(MD)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .pause(pause), .clear(clear),
        .dir(dir), .load_en(load_en), .load_value(load_value), .time_out(time_out),
        .state_out(state_out), .tick(tick), .expired(expired), .load_err(load_err)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] to_bcd(input int s);
        logic [W-1:0] r;
        int m;
        m = s / 60;
        r = '0;
        r[3:0] = 4'((s % 60) % 10);
        r[7:4] = 4'((s % 60) / 10);
        for (int k = 0; k < MD; k++) begin
            r[8 + 4*k +: 4] = 4'((m / (10**k)) % 10);
        end
        return r;
    endfunction

    function automatic bit bcd_ok(input logic [W-1:0] v);
        for (int k = 0; k < MD + 2; k++) begin
            if (v[4*k +: 4] > 4'd9) return 1'b0;
        end
        return v[7:4] <= 4'd5;
    endfunction

    function automatic int bcd_secs(input logic [W-1:0] v);
        int m;
        m = 0;
        for (int k = MD + 1; k >= 2; k--) begin
            m = m * 10 + int'(v[4*k +: 4]);
        end
        return m * 60 + int'(v[7:4]) * 10 + int'(v[3:0]);
    endfunction

    task automatic reset_model();
        m_secs = 0; m_state = 0; m_presc = 0;
        m_dir = 0; m_tick = 0; m_exp = 0; m_lerr = 0;
    endtask

    task automatic model_step(input bit s, input bit p, input bit c, input bit d,
                              input bit l, input logic [W-1:0] lv);
        m_tick = 0; m_exp = 0; m_lerr = 0;
        if (c) begin
            m_state = 0; m_secs = 0; m_presc = 0;
        end else if (l && m_state != 1) begin
            if (bcd_ok(lv)) begin
                m_secs = bcd_secs(lv); m_presc = 0;
                if (m_state == 3) m_state = 0;
            end else begin
                m_lerr = 1;
            end
        end else if (p && m_state == 1) begin
            m_state = 2;
        end else if (s && (m_state == 0 || m_state == 2)) begin
            m_dir = d;
            if (m_state == 0) m_presc = 0;
            if ((d && m_secs == 0) || (!d && m_secs == MAXS)) begin
                m_state = 3; m_exp = 1;
            end else begin
                m_state = 1;
            end
        end else if (m_state == 1) begin
            if (m_presc == DIV - 1) begin
                m_presc = 0;
                m_secs  = m_dir ? m_secs - 1 : m_secs + 1;
                m_tick  = 1;
                if (m_secs == (m_dir ? 0 : MAXS)) begin
                    m_state = 3; m_exp = 1;
                end
            end else begin
                m_presc++;
            end
        end
    endtask

    task automatic cyc(input bit s, input bit p, input bit c, input bit l, input logic [W-1:0] lv);
        start = s; pause = p; clear = c; load_en = l; load_value = lv;
        @(posedge clk);
        model_step(s, p, c, dir, l, lv);
        #1;
        check_val("time",  time_out,  to_bcd(m_secs));
        check_val("state", state_out, m_state);
        check_val("tick",  tick,      m_tick);
        check_val("exp",   expired,   m_exp);
        check_val("lerr",  load_err,  m_lerr);
        if (tick) n_tick++;
        if (expired) n_exp++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, '0);
    endtask

    initial begin
        logic [W-1:0] lv;
        reset_model();
        #12;
        check_val("rst_time", time_out, 0);
        check_val("rst_state", state_out, 0);
        check_val("rst_pulses", {tick, expired, load_err}, 0);
        rst_n = 1'b1;
        idle(2);

        // Up count over ten minutes
        dir = 0;
        cyc(1, 0, 0, 0, '0);
        n_tick = 0; n_exp = 0;
        for (int n = 1; n <= 6000; n++) begin
            cyc(0, 0, 0, 0, '0);
            if (n == 5990) check_val("t5990", time_out, 16'h0959);
        end
        check_val("t6000", time_out, 16'h1000);
        check_val("ticks600", n_tick, 600);
        check_val("noexp", n_exp, 0);

        // Down count to zero
        cyc(0, 0, 1, 0, '0);
        dir = 1;
        cyc(0, 0, 0, 1, 16'h0002);
        cyc(1, 0, 0, 0, '0);
        n_exp = 0;
        for (int n = 1; n <= 20; n++) begin
            cyc(0, 0, 0, 0, '0);
            if (n == 10) check_val("dn10", time_out, 16'h0001);
        end
        check_val("dn20", time_out, 16'h0000);
        check_val("dn_done", state_out, 3);
        check_val("dn_exp", expired, 1);
        cyc(0, 0, 0, 0, '0);
        check_val("dn_exp1", expired, 0);
        idle(100);
        check_val("dn_hold", time_out, 16'h0000);
        check_val("dn_nexp", n_exp, 1);

        // Up to full scale
        dir = 0;
        cyc(0, 0, 0, 1, 16'h9958);
        check_val("ld_idle", state_out, 0);
        cyc(1, 0, 0, 0, '0);
        idle(10);
        check_val("up_full", time_out, 16'h9959);
        check_val("up_done", state_out, 3);
        check_val("up_exp", expired, 1);
        cyc(1, 0, 0, 0, '0);
        check_val("start_done", state_out, 3);
        cyc(0, 0, 1, 0, '0);
        check_val("clr_time", time_out, 0);
        check_val("clr_state", state_out, 0);

        // Pause and resume
        cyc(1, 0, 0, 0, '0);
        idle(15);
        cyc(0, 1, 0, 0, '0);
        check_val("paused", state_out, 2);
        idle(200);
        check_val("pause_hold", time_out, 16'h0001);
        cyc(1, 0, 0, 0, '0);
        for (int n = 1; n <= 5; n++) begin
            cyc(0, 0, 0, 0, '0);
            if (n == 4) check_val("res4", time_out, 16'h0001);
            if (n == 5) check_val("res5", time_out, 16'h0002);
        end
        cyc(1, 1, 0, 0, '0);
        check_val("st_pa", state_out, 2);

        // Load rejection and load in RUN
        cyc(0, 0, 1, 0, '0);
        cyc(0, 0, 0, 1, 16'h0060);
        check_val("lerr60", load_err, 1);
        cyc(0, 0, 0, 1, 16'h00A0);
        check_val("lerrA0", load_err, 1);
        check_val("lerr_t", time_out, 0);
        idle(1);
        check_val("lerr_1cyc", load_err, 0);
        cyc(1, 0, 0, 0, '0);
        cyc(0, 0, 0, 1, 16'h0130);
        check_val("ld_run", load_err, 0);
        idle(3);
        cyc(0, 0, 1, 0, '0);
        dir = 1;
        cyc(1, 0, 0, 0, '0);
        check_val("zstart", state_out, 3);
        check_val("zexp", expired, 1);
        check_val("ztick", tick, 0);

        // Asynchronous reset mid-count
        cyc(0, 0, 1, 0, '0);
        dir = 0;
        cyc(1, 0, 0, 0, '0);
        idle(420);
        check_val("t42", time_out, 16'h0042);
        #2 rst_n = 1'b0;
        #1;
        check_val("arst_time", time_out, 0);
        check_val("arst_state", state_out, 0);
        reset_model();
        @(posedge clk);
        #1;
        check_val("arst_hold", {time_out, tick, expired}, 0);
        rst_n = 1'b1;
        idle(2);

        // Random phase
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 99) < 3) dir = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 3))
                0:       lv = W'($urandom);
                1:       lv = to_bcd($urandom_range(0, MAXS));
                2:       lv = to_bcd($urandom_range(0, 3));
                default: lv = to_bcd(MAXS - int'($urandom_range(0, 3)));
            endcase
            cyc($urandom_range(0, 99) < 10, $urandom_range(0, 99) < 5,
                $urandom_range(0, 99) < 2,  $urandom_range(0, 99) < 4, lv);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
